// File: rtl/rx_sequence_correlator_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// rx_sequence_correlator_pkg : shared constants and sweep state encoding
// Rev 1.0
// ==========================================================================
package rx_sequence_correlator_pkg;

    localparam int N_SEQ      = 16;
    localparam int SEQ_LEN    = 255;
    localparam int RING_DEPTH = 256;
    localparam int RING_AW    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rx_sample_ring_256.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// rx_sample_ring_256 : 256-entry simple dual-port sample RAM, registered read
// Rev 1.0
// ==========================================================================
module rx_sample_ring_256
    import rx_sequence_correlator_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [RING_AW-1:0]  wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic [RING_AW-1:0]  rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    // No reset on storage or read port so the array maps onto block RAM.
    logic [SAMPLE_W-1:0] mem [RING_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/rx_sequence_correlator.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// rx_sequence_correlator : correlates the last 255 samples against 16 sequences
// Rev 1.0
// ==========================================================================
module rx_sequence_correlator
    import rx_sequence_correlator_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = SAMPLE_W + 8
) (
    input  logic                      crx_clk,
    input  logic                      rrx_rst,
    input  logic                      erx_en,
    input  logic                      inew_sample_trig,
    input  logic [SAMPLE_W-1:0]       isample,
    input  logic [N_SEQ-1:0]          isequences_bits,
    output logic [N_SEQ*ACC_W-1:0]    ocorr,
    output logic [3:0]                obest_seq,
    output logic [ACC_W-1:0]          obest_mag,
    output logic                      ocorr_valid,
    output logic                      obusy
);

    state_t               state, state_next;
    logic [RING_AW-1:0]   wp;
    logic [RING_AW-1:0]   base;
    logic [RING_AW-1:0]   chip;
    logic [7:0]           fill;
    logic                 phase;
    logic [SAMPLE_W-1:0]  rd_data;
    logic [RING_AW-1:0]   rd_addr;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] acc [N_SEQ];
    logic [ACC_W-1:0]     mag [N_SEQ];
    logic [3:0]           best_idx;
    logic [ACC_W-1:0]     best_mag;
    logic                 trig;

    assign trig       = erx_en & inew_sample_trig;
    assign rd_addr    = base + chip;
    assign sample_ext = {{(ACC_W-SAMPLE_W){rd_data[SAMPLE_W-1]}}, rd_data};
    assign obusy      = (state != IDLE);

    rx_sample_ring_256 #(
        .SAMPLE_W (SAMPLE_W)
    ) u_ring (
        .clk     (crx_clk),
        .wr_en   (trig),
        .wr_addr (wp),
        .wr_data (isample),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A trigger always restarts the sweep, aborting any sweep in flight.
    always_comb begin
        state_next = state;
        if (!erx_en) begin
            state_next = IDLE;
        end else if (inew_sample_trig) begin
            state_next = SWEEP;
        end else begin
            case (state)
                SWEEP:   if (phase && chip == 8'(SEQ_LEN - 1)) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        for (int j = 0; j < N_SEQ; j++) begin
            mag[j] = acc[j][ACC_W-1] ? ACC_W'(-acc[j]) : ACC_W'(acc[j]);
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_mag = '0;
        for (int j = 0; j < N_SEQ; j++) begin
            if (mag[j] > best_mag) begin
                best_idx = 4'(j);
                best_mag = mag[j];
            end
        end
    end

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            wp          <= '0;
            base        <= '0;
            chip        <= '0;
            fill        <= '0;
            phase       <= 1'b0;
            ocorr       <= '0;
            obest_seq   <= '0;
            obest_mag   <= '0;
            ocorr_valid <= 1'b0;
            for (int j = 0; j < N_SEQ; j++) acc[j] <= '0;
        end else if (!erx_en) begin
            wp          <= '0;
            chip        <= '0;
            fill        <= '0;
            phase       <= 1'b0;
            ocorr_valid <= 1'b0;
            for (int j = 0; j < N_SEQ; j++) acc[j] <= '0;
        end else begin
            ocorr_valid <= 1'b0;
            if (inew_sample_trig) begin
                wp    <= wp + 8'd1;
                base  <= wp + 8'd2;
                fill  <= (fill == 8'(SEQ_LEN)) ? fill : fill + 8'd1;
                chip  <= '0;
                phase <= 1'b0;
                for (int j = 0; j < N_SEQ; j++) acc[j] <= '0;
            end else if (state == SWEEP) begin
                phase <= ~phase;
                if (phase) begin
                    chip <= chip + 8'd1;
                    for (int j = 0; j < N_SEQ; j++) begin
                        acc[j] <= isequences_bits[j] ? acc[j] + sample_ext
                                                     : acc[j] - sample_ext;
                    end
                end
            end else if (state == DONE) begin
                if (fill == 8'(SEQ_LEN)) begin
                    for (int j = 0; j < N_SEQ; j++) begin
                        ocorr[j*ACC_W +: ACC_W] <= acc[j];
                    end
                    obest_seq   <= best_idx;
                    obest_mag   <= best_mag;
                    ocorr_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_sequence_correlator.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_rx_sequence_correlator : directed self-checking bench for the correlator
// Rev 1.0
// ==========================================================================
module tb_rx_sequence_correlator;

    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = SAMPLE_W + 8;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic                   trig;
    logic [SAMPLE_W-1:0]    sample;
    logic [15:0]            bits;
    logic [16*ACC_W-1:0]    ocorr;
    logic [3:0]             best_seq;
    logic [ACC_W-1:0]       best_mag;
    logic                   valid;
    logic                   busy;

    int n_cmp  = 0;
    int n_bad  = 0;
    int vcount = 0;

    rx_sequence_correlator #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) dut (
        .crx_clk          (clk),
        .rrx_rst          (rst),
        .erx_en           (en),
        .inew_sample_trig (trig),
        .isample          (sample),
        .isequences_bits  (bits),
        .ocorr            (ocorr),
        .obest_seq        (best_seq),
        .obest_mag        (best_mag),
        .ocorr_valid      (valid),
        .obusy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (valid === 1'b1) vcount <= vcount + 1;
    end

    function automatic logic signed [ACC_W-1:0] corr(input int j);
        return ocorr[j*ACC_W +: ACC_W];
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic signed [SAMPLE_W-1:0] s);
        trig   = 1'b1;
        sample = s;
        @(posedge clk);
        #1;
        trig   = 1'b0;
    endtask

    // Present chip k's sequence bits just before the edge that accumulates it.
    task automatic sweep_bits(input int mode);
        for (int k = 0; k < 255; k++) begin
            @(posedge clk);
            #1;
            case (mode)
                1:       bits = (k % 3 == 0) ? 16'h0020 : 16'h0000;
                2:       bits = 16'hFFFF;
                default: bits = (k < 200) ? 16'hFFFF : 16'h0200;
            endcase
            @(posedge clk);
            #1;
        end
    endtask

    int vsnap;

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        trig   = 1'b0;
        sample = '0;
        bits   = '0;
        repeat (3) tick();
        check("rst_corr",  ocorr == '0, 1);
        check("rst_seq",   best_seq, 0);
        check("rst_mag",   best_mag, 0);
        check("rst_valid", valid, 0);
        check("rst_busy",  busy, 0);
        rst = 1'b0;
        tick();

        // Warm-up: 254 samples, the last allowed to sweep to completion.
        for (int i = 0; i < 254; i++) begin
            fire((i % 3 == 0) ? 16'sd1000 : -16'sd1000);
            if (i == 0) check("busy_after_trig", busy, 1);
            if (i < 253) tick();
        end
        repeat (520) tick();
        check("warmup_no_valid", vcount, 0);

        // 255th sample: matched pattern on sequence 5.
        fire(-16'sd1000);
        sweep_bits(1);
        check("match_valid_early", valid, 0);
        tick();
        check("match_valid",   valid, 1);
        check("match_corr5",   corr(5), 255000);
        check("match_corr0",   corr(0), 85000);
        check("match_corr15",  corr(15), 85000);
        check("match_best",    best_seq, 5);
        check("match_mag",     best_mag, 255000);
        tick();
        check("match_pulse_1cyc", valid, 0);

        // Extremes: full window of -32768 with every bit set.
        bits = 16'hFFFF;
        for (int i = 0; i < 254; i++) begin
            fire(-16'sd32768);
            tick();
        end
        vsnap = vcount;
        fire(-16'sd32768);
        sweep_bits(2);
        tick();
        check("ext_valid",  valid, 1);
        check("ext_count",  vcount - vsnap, 0);
        check("ext_corr0",  corr(0), -8355840);
        check("ext_corr15", corr(15), -8355840);
        check("ext_best",   best_seq, 0);
        check("ext_mag",    best_mag, 8355840);
        tick();

        // Abort: second trigger 300 edges after the first.
        vsnap = vcount;
        fire(-16'sd32768);
        repeat (299) tick();
        fire(16'sd0);
        sweep_bits(2);
        check("abort_no_valid", vcount - vsnap, 0);
        check("abort_valid_early", valid, 0);
        tick();
        check("abort_valid", valid, 1);
        check("abort_corr3", corr(3), -8323072);
        check("abort_best",  best_seq, 0);
        check("abort_mag",   best_mag, 8323072);
        tick();

        // Disable mid-sweep, then a fresh warm-up is required.
        fire(16'sd5);
        repeat (99) tick();
        en = 1'b0;
        tick();
        check("dis_busy",  busy, 0);
        check("dis_valid", valid, 0);
        check("dis_mag_held",  best_mag, 8323072);
        check("dis_corr_held", corr(3), -8323072);
        en = 1'b1;
        vsnap = vcount;
        for (int i = 0; i < 254; i++) begin
            fire(16'sd100);
            if (i < 253) tick();
        end
        repeat (520) tick();
        check("reen_warmup_no_valid", vcount - vsnap, 0);
        fire(16'sd100);
        sweep_bits(3);
        tick();
        check("reen_valid", valid, 1);
        check("reen_corr9", corr(9), 25500);
        check("reen_corr0", corr(0), 14500);
        check("reen_best",  best_seq, 9);
        check("reen_mag",   best_mag, 25500);
        tick();

        // Asynchronous reset mid-sweep, between clock edges.
        fire(16'sd100);
        repeat (199) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_corr",  ocorr == '0, 1);
        check("arst_seq",   best_seq, 0);
        check("arst_mag",   best_mag, 0);
        check("arst_busy",  busy, 0);
        check("arst_valid", valid, 0);
        repeat (2) tick();
        rst = 1'b0;
        vsnap = vcount;
        repeat (600) tick();
        check("arst_no_valid", vcount - vsnap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
